// File: rtl/mux4way_arbiter.sv
// mux4way_arbiter: gathers four word streams (a, b, c, d) into one registered
// output stream with round-robin, packet-atomic arbitration.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no packet in progress; grant the first requester from ptr
//   LOCKED | owner has an open packet; only owner may transfer until last
//
// Source index encoding on out_sel: 00=a, 01=b, 10=c, 11=d.
module mux4way_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;

  logic             load;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             capture;
  logic [WIDTH-1:0] data_arr [4];

  // Output register can take a new beat when empty or being drained this cycle.
  assign load    = !out_valid || out_ready;
  assign capture = !reset && load && grant_any;

  // Split the packed input bus into one word per source.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      data_arr[k] = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Grant selection: owner while locked, otherwise circular search from ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    cand      = '0;
    if (state_q == LOCKED) begin
      grant_idx = owner_q;
      grant_any = in_valid[owner_q];
    end else begin
      // Walk from the farthest offset down so the nearest requester wins.
      for (int k = 3; k >= 0; k--) begin
        cand = ptr_q + 2'(k);
        if (in_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Ready back to the sources; the owner sees load even while its valid is low.
  always_comb begin
    in_ready = '0;
    if (!reset && load) begin
      if (state_q == LOCKED) begin
        in_ready[owner_q] = 1'b1;
      end else if (grant_any) begin
        in_ready[grant_idx] = 1'b1;
      end
    end
  end

  // Next-state logic: lock on a non-last beat, release and rotate on last.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (capture) begin
      if (in_last[grant_idx]) begin
        state_d = IDLE;
        ptr_d   = grant_idx + 2'd1;
      end else begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Output beat register; payload holds when nothing new is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 2'd0;
    end else if (load) begin
      out_valid <= capture;
      if (capture) begin
        out_data <= data_arr[grant_idx];
        out_last <= in_last[grant_idx];
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux4way_arbiter.sv
// tb_mux4way_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a packet-level reference model of the arbiter.
module tb_mux4way_arbiter;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         in_valid;
  logic [3:0]         in_last;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [1:0]         out_sel;
  logic               out_ready;

  logic [WIDTH-1:0]   dd [4];

  int tests = 0;
  int fails = 0;

  // reference model: pointer, owner (-1 = no open packet), output register
  int               m_ptr;
  int               m_owner;
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic             m_ol;
  logic [1:0]       m_os;
  logic [3:0]       ir_seen;

  mux4way_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  assign in_data = {dd[3], dd[2], dd[1], dd[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check ready against the model, clock, check outputs.
  task automatic step();
    logic       load;
    logic       cap;
    logic       found;
    int         src;
    logic [3:0] exp_r;
    #1;
    load  = !m_ov || out_ready;
    cap   = 1'b0;
    found = 1'b0;
    src   = 0;
    exp_r = 4'b0000;
    if (!reset) begin
      if (m_owner >= 0) begin
        src = m_owner;
        if (load) exp_r[src] = 1'b1;
        cap = load && in_valid[src];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (!found && in_valid[(m_ptr + i) % 4]) begin
            found = 1'b1;
            src   = (m_ptr + i) % 4;
          end
        end
        cap = load && found;
        if (cap) exp_r[src] = 1'b1;
      end
    end
    ir_seen = in_ready;
    chk("model_in_ready", {28'd0, in_ready}, {28'd0, exp_r});
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_owner = -1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_os = 2'd0;
    end else if (cap) begin
      m_ov = 1'b1;
      m_od = dd[src];
      m_ol = in_last[src];
      m_os = 2'(src);
      if (in_last[src]) begin
        m_owner = -1;
        m_ptr   = (src + 1) % 4;
      end else begin
        m_owner = src;
      end
    end else if (load) begin
      m_ov = 1'b0;
    end
    #1;
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("model_out_data",  {16'd0, out_data},  {16'd0, m_od});
    chk("model_out_last",  {31'd0, out_last},  {31'd0, m_ol});
    chk("model_out_sel",   {30'd0, out_sel},   {30'd0, m_os});
  endtask

  initial begin
    m_ptr = 0; m_owner = -1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_os = 2'd0;
    reset = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dd[i] = 16'(16'hA000 + i);

    // reset with every source requesting
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_in_ready", {28'd0, ir_seen}, 32'h0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
      chk("rst_out_sel", {30'd0, out_sel}, 32'h0);
    end
    reset = 1'b0;

    // round robin with single-beat packets, a first after reset
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 4; i++) dd[i] = 16'(16'h1000 * (i + 1) + k);
      step();
      chk("rr_in_ready", {28'd0, ir_seen}, 32'(1 << (k % 4)));
      chk("rr_out_sel", {30'd0, out_sel}, 32'(k % 4));
      chk("rr_out_valid", {31'd0, out_valid}, 32'h1);
    end

    // b sends a 3-beat packet while a, c, d keep requesting
    in_valid = 4'b1111; in_last = 4'b1101;
    dd[1] = 16'h1111; step();
    chk("lock_ready1", {28'd0, ir_seen}, 32'b0010);
    chk("lock_sel1", {30'd0, out_sel}, 32'd1);
    chk("lock_last1", {31'd0, out_last}, 32'd0);
    dd[1] = 16'h2222; step();
    chk("lock_ready2", {28'd0, ir_seen}, 32'b0010);
    chk("lock_data2", {16'd0, out_data}, 32'h2222);
    in_last = 4'b1111;
    dd[1] = 16'h3333; step();
    chk("lock_ready3", {28'd0, ir_seen}, 32'b0010);
    chk("lock_last3", {31'd0, out_last}, 32'd1);
    chk("lock_sel3", {30'd0, out_sel}, 32'd1);

    // c wins next and presents 0xBEEF, then the consumer stalls
    dd[2] = 16'hBEEF; step();
    chk("next_grant_c", {28'd0, ir_seen}, 32'b0100);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_in_ready", {28'd0, ir_seen}, 32'h0);
      chk("bp_out_data", {16'd0, out_data}, 32'hBEEF);
      chk("bp_out_valid", {31'd0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    in_last = 4'b0111; dd[3] = 16'hD001;
    step();
    chk("bp_release_ready", {28'd0, ir_seen}, 32'b1000);
    chk("bp_release_data", {16'd0, out_data}, 32'hD001);

    // d owns the output and goes quiet while a asks
    in_valid = 4'b0001; in_last = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("gap_in_ready", {28'd0, ir_seen}, 32'b1000);
      chk("gap_out_valid", {31'd0, out_valid}, 32'h0);
    end
    in_valid = 4'b1001; in_last = 4'b0001; dd[3] = 16'hD002;
    step();
    chk("gap_d2_data", {16'd0, out_data}, 32'hD002);
    in_last = 4'b1001; dd[3] = 16'hD003;
    step();
    chk("gap_d3_last", {31'd0, out_last}, 32'h1);
    in_valid = 4'b0001; dd[0] = 16'hA0A0;
    step();
    chk("gap_then_a", {28'd0, ir_seen}, 32'b0001);
    chk("gap_then_a_sel", {30'd0, out_sel}, 32'd0);

    // reset during the second beat of a packet from c
    in_valid = 4'b0100; in_last = 4'b0000; dd[2] = 16'hC001;
    step();
    chk("mid_c1_ready", {28'd0, ir_seen}, 32'b0100);
    reset = 1'b1; dd[2] = 16'hC002;
    step();
    chk("mid_rst_ready", {28'd0, ir_seen}, 32'h0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'h0);
    reset = 1'b0; in_valid = 4'b0101; in_last = 4'b0101;
    step();
    chk("mid_after_a", {28'd0, ir_seen}, 32'b0001);

    // random traffic with occasional backpressure and reset
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) dd[i] = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
